// File: rtl/mux2_rr_feeder_pkg.sv
// Shared source encodings for the two-source round-robin feeder.
// sel=0 steers the downstream 2:1 mux to source A.
package mux2_rr_feeder_pkg;

  typedef logic src_t;

  localparam src_t SRC_A = 1'b0;
  localparam src_t SRC_B = 1'b1;

  function automatic src_t other_src(src_t s);
    return ~s;
  endfunction

endpackage

// File: rtl/mux2_rr_feeder_grant.sv
// Combinational round-robin grant for two sources with a burst cap.
// The owner keeps the grant until it has used its burst while the other side waits.
module mux2_rr_feeder_grant
  import mux2_rr_feeder_pkg::*;
#(
  parameter int unsigned BURST = 4,
  parameter int unsigned CNTW  = $clog2(BURST) + 1
) (
  input  logic            owner_i,
  input  logic [CNTW-1:0] cnt_i,
  input  logic            a_valid_i,
  input  logic            b_valid_i,
  input  logic            load_i,
  output logic            gnt_valid_o,
  output logic            gnt_id_o
);

  localparam logic [CNTW-1:0] CntMax = CNTW'(BURST - 1);

  logic own_v;
  logic oth_v;

  assign own_v = (owner_i == SRC_B) ? b_valid_i : a_valid_i;
  assign oth_v = (owner_i == SRC_B) ? a_valid_i : b_valid_i;

  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_id_o    = owner_i;
    if (load_i) begin
      if (own_v && ((cnt_i < CntMax) || !oth_v)) begin
        gnt_valid_o = 1'b1;
        gnt_id_o    = owner_i;
      end else if (oth_v) begin
        gnt_valid_o = 1'b1;
        gnt_id_o    = other_src(owner_i);
      end
    end
  end

endmodule

// File: rtl/mux2_rr_feeder.sv
// Two-source round-robin arbiter with a registered output beat and mux select.
// One beat per cycle at full throughput; output register stalls on ~out_ready.
module mux2_rr_feeder
  import mux2_rr_feeder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned BURST = 4,
  parameter int unsigned CNTW  = $clog2(BURST) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             sel
);

  localparam logic [CNTW-1:0] CntMax = CNTW'(BURST - 1);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             sel_q, sel_d;
  logic             owner_q, owner_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  logic load;
  logic gnt_valid;
  logic gnt_id;

  assign load = ~out_valid_q | out_ready;

  mux2_rr_feeder_grant #(
    .BURST(BURST),
    .CNTW (CNTW)
  ) u_grant (
    .owner_i    (owner_q),
    .cnt_i      (cnt_q),
    .a_valid_i  (a_valid),
    .b_valid_i  (b_valid),
    .load_i     (load),
    .gnt_valid_o(gnt_valid),
    .gnt_id_o   (gnt_id)
  );

  // Gate with rst so nothing is accepted while the register is being cleared.
  assign a_ready = ~rst & gnt_valid & (gnt_id == SRC_A);
  assign b_ready = ~rst & gnt_valid & (gnt_id == SRC_B);

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    sel_d       = sel_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    if (gnt_valid) begin
      out_valid_d = 1'b1;
      out_data_d  = (gnt_id == SRC_B) ? b_data : a_data;
      sel_d       = gnt_id;
      if (gnt_id == owner_q) begin
        cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CNTW'(1);
      end else begin
        owner_d = gnt_id;
        cnt_d   = '0;
      end
    end else if (load) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sel_q       <= SRC_A;
      owner_q     <= SRC_A;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sel_q       <= sel_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sel       = sel_q;

endmodule
